// File: rtl/sc_timer_t0_if.sv
// sc_timer_t0_if -- control/status bundle between the shift-control state
// machine (master) and the event timer (slave).
//   SC_TIMERT0_upcount_InLow  master->slave  count strobe, low = one event
//   SC_TIMERT0_clear_InLow    master->slave  restart the count, limit kept
//   SC_TIMERT0_load_InLow     master->slave  load a new limit from data_In
//   SC_TIMERT0_data_In        master->slave  new limit value
//   SC_TIMERT0_T0_OutLow      slave->master  expiry flag, low while expired
//   SC_TIMERT0_count_Out      slave->master  current count register
interface sc_timer_t0_if #(
  parameter int DATAWIDTH = 8
);
  logic                 SC_TIMERT0_upcount_InLow;
  logic                 SC_TIMERT0_clear_InLow;
  logic                 SC_TIMERT0_load_InLow;
  logic [DATAWIDTH-1:0] SC_TIMERT0_data_In;
  logic                 SC_TIMERT0_T0_OutLow;
  logic [DATAWIDTH-1:0] SC_TIMERT0_count_Out;

  modport master (
    output SC_TIMERT0_upcount_InLow,
    output SC_TIMERT0_clear_InLow,
    output SC_TIMERT0_load_InLow,
    output SC_TIMERT0_data_In,
    input  SC_TIMERT0_T0_OutLow,
    input  SC_TIMERT0_count_Out
  );

  modport slave (
    input  SC_TIMERT0_upcount_InLow,
    input  SC_TIMERT0_clear_InLow,
    input  SC_TIMERT0_load_InLow,
    input  SC_TIMERT0_data_In,
    output SC_TIMERT0_T0_OutLow,
    output SC_TIMERT0_count_Out
  );
endinterface

// File: rtl/sc_timer_t0.sv
// sc_timer_t0 -- programmable event timer for the background shift-control
// state machine. Counts active-low upcount strobes; once the programmed limit
// is reached T0_OutLow goes low and stays low until the next strobe
// acknowledges it, so a periodically sampling master cannot miss it.
//
// Ports:
//   SC_TIMERT0_CLOCK_50      system clock, rising edge
//   SC_TIMERT0_RESET_InLow   asynchronous active-low reset
//   bus (slave modport)      strobe/clear/load/data in, T0 flag and count out
//
// Optional feature: define SC_TIMERT0_PRESCALER_EN to insert a
// PRESCALER_BITS-wide prescaler so the count advances once per
// 2^PRESCALER_BITS strobes.
//
// state       | meaning
// ------------+---------------------------------------------
// ST_STOPPED  | limit is 0, strobes ignored, count held at 0
// ST_RUNNING  | counting strobes toward limit
// ST_EXPIRED  | limit reached, T0 low, waiting for acknowledge
// (2'b11)     | unused, recovers to ST_STOPPED
module sc_timer_t0 #(
  parameter int                   DATAWIDTH      = 8,
  parameter logic [DATAWIDTH-1:0] LIMIT_INIT     = 8'd16,
  parameter int                   PRESCALER_BITS = 4
) (
  input logic           SC_TIMERT0_CLOCK_50,
  input logic           SC_TIMERT0_RESET_InLow,
  sc_timer_t0_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_RUNNING = 2'b01,
    ST_EXPIRED = 2'b10
  } state_t;

  if (PRESCALER_BITS < 1) begin : g_bad_presc
    $error("sc_timer_t0: PRESCALER_BITS must be at least 1");
  end

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] count_q, count_d;
  logic [DATAWIDTH-1:0] limit_q, limit_d;
  logic                 t0_n_q, t0_n_d;
  logic [DATAWIDTH-1:0] count_inc;
  logic                 strobe;
  logic                 advance;

`ifdef SC_TIMERT0_PRESCALER_EN
  logic [PRESCALER_BITS-1:0] presc_q, presc_d;
`endif

  assign strobe    = ~bus.SC_TIMERT0_upcount_InLow;
  assign count_inc = count_q + 1'b1;

  // A strobe in RUNNING moves the count only when the prescaler (if present)
  // is about to wrap.
`ifdef SC_TIMERT0_PRESCALER_EN
  assign advance = strobe & (&presc_q);
`else
  assign advance = strobe;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
`ifdef SC_TIMERT0_PRESCALER_EN
    presc_d = presc_q;
`endif
    if (!bus.SC_TIMERT0_clear_InLow) begin
      count_d = '0;
`ifdef SC_TIMERT0_PRESCALER_EN
      presc_d = '0;
`endif
      state_d = (limit_q != '0) ? ST_RUNNING : ST_STOPPED;
    end else if (!bus.SC_TIMERT0_load_InLow) begin
      limit_d = bus.SC_TIMERT0_data_In;
      count_d = '0;
`ifdef SC_TIMERT0_PRESCALER_EN
      presc_d = '0;
`endif
      state_d = (bus.SC_TIMERT0_data_In != '0) ? ST_RUNNING : ST_STOPPED;
    end else begin
      case (state_q)
        ST_STOPPED: begin
          count_d = '0;
        end
        ST_RUNNING: begin
`ifdef SC_TIMERT0_PRESCALER_EN
          if (strobe) presc_d = presc_q + 1'b1;
`endif
          if (advance) begin
            // count stays below limit, so count_inc never wraps here
            if (count_inc == limit_q) begin
              count_d = limit_q;
              state_d = ST_EXPIRED;
            end else begin
              count_d = count_inc;
            end
          end
        end
        ST_EXPIRED: begin
          if (strobe) begin
            count_d = '0;
`ifdef SC_TIMERT0_PRESCALER_EN
            presc_d = '0;
`endif
            state_d = ST_RUNNING;
          end
        end
        default: begin
          count_d = '0;
`ifdef SC_TIMERT0_PRESCALER_EN
          presc_d = '0;
`endif
          state_d = ST_STOPPED;
        end
      endcase
    end
    // flag decoded from the next state so it is registered alongside it
    t0_n_d = (state_d != ST_EXPIRED);
  end

  always_ff @(posedge SC_TIMERT0_CLOCK_50 or negedge SC_TIMERT0_RESET_InLow) begin
    if (!SC_TIMERT0_RESET_InLow) begin
      state_q <= (LIMIT_INIT != '0) ? ST_RUNNING : ST_STOPPED;
      count_q <= '0;
      limit_q <= LIMIT_INIT;
      t0_n_q  <= 1'b1;
`ifdef SC_TIMERT0_PRESCALER_EN
      presc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      t0_n_q  <= t0_n_d;
`ifdef SC_TIMERT0_PRESCALER_EN
      presc_q <= presc_d;
`endif
    end
  end

  assign bus.SC_TIMERT0_T0_OutLow = t0_n_q;
  assign bus.SC_TIMERT0_count_Out = count_q;

endmodule

// File: tb/tb_sc_timer_t0.sv
// tb_sc_timer_t0 -- bench for sc_timer_t0. A behavioural model tracks the
// count as a plain integer event tally against the limit; a compare process
// checks the DUT against it on every falling edge, and directed sequences pin
// the model with hand-computed literal values.
module tb_sc_timer_t0;
  localparam int DW = 8;
  localparam int PB = 2;
  localparam int LIMIT_RST = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  sc_timer_t0_if #(.DATAWIDTH(DW)) bus ();

  sc_timer_t0 #(
    .DATAWIDTH(DW),
    .LIMIT_INIT(8'd16),
    .PRESCALER_BITS(PB)
  ) dut (
    .SC_TIMERT0_CLOCK_50(clk),
    .SC_TIMERT0_RESET_InLow(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    int limit;
    bit expired;
    int presc;
  } mstate_t;

  mstate_t m = '{count: 0, limit: LIMIT_RST, expired: 1'b0, presc: 0};

  // Behavioural rules: clear > load > strobe; a limit of 0 means stopped.
  function automatic mstate_t model_next(mstate_t s, bit up_n, bit clr_n, bit ld_n, int data);
    mstate_t n = s;
    if (!clr_n) begin
      n.count = 0; n.presc = 0; n.expired = 1'b0;
    end else if (!ld_n) begin
      n.limit = data; n.count = 0; n.presc = 0; n.expired = 1'b0;
    end else if (!up_n && s.limit != 0) begin
      if (s.expired) begin
        n.count = 0; n.presc = 0; n.expired = 1'b0;
      end else begin
        bit tick = 1'b1;
`ifdef SC_TIMERT0_PRESCALER_EN
        n.presc = s.presc + 1;
        tick = (n.presc == (1 << PB));
        if (tick) n.presc = 0;
`endif
        if (tick) begin
          n.count = s.count + 1;
          if (n.count == s.limit) n.expired = 1'b1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      m <= '{count: 0, limit: LIMIT_RST, expired: 1'b0, presc: 0};
    else
      m <= model_next(m, bus.SC_TIMERT0_upcount_InLow, bus.SC_TIMERT0_clear_InLow,
                      bus.SC_TIMERT0_load_InLow, int'(bus.SC_TIMERT0_data_In));
  end

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("model_t0", int'(bus.SC_TIMERT0_T0_OutLow), m.expired ? 0 : 1);
    check("model_count", int'(bus.SC_TIMERT0_count_Out), m.count);
  end

  task automatic drive(bit up_n, bit clr_n, bit ld_n, int data);
    bus.SC_TIMERT0_upcount_InLow = up_n;
    bus.SC_TIMERT0_clear_InLow   = clr_n;
    bus.SC_TIMERT0_load_InLow    = ld_n;
    bus.SC_TIMERT0_data_In       = DW'(data);
    @(posedge clk);
    #1;
    bus.SC_TIMERT0_upcount_InLow = 1'b1;
    bus.SC_TIMERT0_clear_InLow   = 1'b1;
    bus.SC_TIMERT0_load_InLow    = 1'b1;
  endtask

  task automatic strobes(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, 0);
  endtask

  task automatic idles(int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1, 0);
  endtask

  task automatic expect_out(string name, int t0, int cnt);
    check({name, "_t0"}, int'(bus.SC_TIMERT0_T0_OutLow), t0);
    check({name, "_count"}, int'(bus.SC_TIMERT0_count_Out), cnt);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SC_TIMERT0_upcount_InLow = 1'b1;
    bus.SC_TIMERT0_clear_InLow   = 1'b1;
    bus.SC_TIMERT0_load_InLow    = 1'b1;
    bus.SC_TIMERT0_data_In       = '0;
    repeat (3) @(posedge clk);
    #1;
    expect_out("in_reset", 1, 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out("after_reset", 1, 0);

`ifndef SC_TIMERT0_PRESCALER_EN
    strobes(15);
    expect_out("pre_expiry", 1, 15);
    strobes(1);
    expect_out("expiry16", 0, 16);
    idles(20);
    expect_out("held20", 0, 16);
    strobes(1);
    expect_out("ack17", 1, 0);

    drive(1'b1, 1'b1, 1'b0, 3);
    expect_out("load3", 1, 0);
    strobes(2);
    expect_out("load3_two", 1, 2);
    strobes(1);
    expect_out("load3_expiry", 0, 3);
    drive(1'b1, 1'b0, 1'b1, 0);
    expect_out("clear_expired", 1, 0);

    drive(1'b1, 1'b1, 1'b0, 0);
    strobes(10);
    expect_out("stopped", 1, 0);

    drive(1'b1, 1'b1, 1'b0, 7);
    strobes(2);
    expect_out("load7_two", 1, 2);
    drive(1'b0, 1'b0, 1'b0, 5);
    expect_out("priority", 1, 0);
    strobes(6);
    expect_out("limit_kept_six", 1, 6);
    strobes(1);
    expect_out("limit_kept_expiry", 0, 7);

    drive(1'b1, 1'b1, 1'b0, 1);
    strobes(1);
    expect_out("limit1", 0, 1);
    strobes(1);
    expect_out("limit1_ack", 1, 0);

    do_reset();
    strobes(9);
    expect_out("mid_count9", 1, 9);
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_reset", 1, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
`else
    drive(1'b1, 1'b1, 1'b0, 3);
    strobes(11);
    expect_out("presc_eleven", 1, 2);
    strobes(1);
    expect_out("presc_twelve", 0, 3);
    strobes(1);
    expect_out("presc_ack", 1, 0);
    strobes(3);
    expect_out("presc_three", 1, 0);
    strobes(1);
    expect_out("presc_four", 1, 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      int r = int'($urandom_range(0, 99));
      bit clr_n = (r >= 3);
      bit ld_n  = !(r >= 3 && r < 7);
      bit up_n  = ($urandom_range(0, 1) == 0);
      int data  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 6));
      drive(up_n, clr_n, ld_n, data);
    end
    idles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
